// File: rtl/aha_platform_pkg.sv
// Shared definitions for the peripheral reset sequencer: FSM state encoding
// and default parameter values.
package aha_platform_pkg;

  localparam int DEF_NUM_CH         = 11;
  localparam int DEF_HOLD_CYCLES    = 4;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ASSERT   = 3'd1,
    ST_HOLD     = 3'd2,
    ST_RELEASE  = 3'd3,
    ST_COMPLETE = 3'd4
  } rst_state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/aha_rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past i_ptr and wraps,
// returning a one-hot grant plus its binary index.
module aha_rr_arbiter #(
  parameter  int N  = 11,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx
);

  logic          w_found;
  logic [IW-1:0] w_cidx;
  int            w_c;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_cidx  = '0;
    w_c     = 0;
    for (int k = 1; k <= N; k++) begin
      w_c = int'(i_ptr) + k;
      if (w_c >= N) w_c = w_c - N;
      w_cidx = IW'(w_c);
      if (!w_found && i_req[w_cidx]) begin
        w_found       = 1'b1;
        o_gnt[w_cidx] = 1'b1;
        o_idx         = w_cidx;
      end
    end
  end

endmodule

// File: rtl/aha_periph_reset_seq.sv
// Peripheral reset sequencer: queues per-channel reset requests and runs a
// REQ/ACK handshake on one channel at a time, chosen round-robin.
// Define AHA_RST_SEQ_TIMEOUT_EN to enable the ASSERT/RELEASE timeout and ERR.
module aha_periph_reset_seq
  import aha_platform_pkg::*;
#(
  parameter  int NUM_CH         = DEF_NUM_CH,
  parameter  int HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter  int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  localparam int CNT_W          = $clog2(max2(HOLD_CYCLES, TIMEOUT_CYCLES) + 1),
  localparam int IDX_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic [NUM_CH-1:0] PEND_SET,
  output logic [NUM_CH-1:0] RESET_REQ,
  input  logic [NUM_CH-1:0] RESET_ACK,
  output logic [NUM_CH-1:0] PENDING,
  output logic [NUM_CH-1:0] DONE,
  output logic [NUM_CH-1:0] ERR,
  input  logic [NUM_CH-1:0] ERR_CLR,
  output logic              BUSY
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};

  rst_state_e        r_state, w_nxt;
  logic [CNT_W-1:0]  r_cnt;
  // r_ch doubles as the round-robin pointer (last serviced channel).
  logic [IDX_W-1:0]  r_ch, w_gnt_idx, w_ch_nxt;
  logic [NUM_CH-1:0] r_pend, r_req, r_done;
  logic [NUM_CH-1:0] w_gnt, w_req_nxt, w_done_nxt, w_pend_clr, w_ch_oh;
  logic              w_ack, w_grant_en, w_to, w_to_hit;

  aha_rr_arbiter #(.N(NUM_CH)) u_arb (
    .i_req (r_pend),
    .i_ptr (r_ch),
    .o_gnt (w_gnt),
    .o_idx (w_gnt_idx)
  );

  assign w_ack   = RESET_ACK[r_ch];
  assign w_ch_oh = NUM_CH'(1) << r_ch;

`ifdef AHA_RST_SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [NUM_CH-1:0] r_err;

  assign w_to_hit = (r_cnt == TO_LAST);

  // A timeout set in the same cycle as a clear leaves the flag set.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) r_err <= '0;
    else         r_err <= (r_err & ~ERR_CLR) | (w_to ? w_ch_oh : '0);
  end

  assign ERR = r_err;
`else
  logic w_unused_errclr;

  assign w_to_hit        = 1'b0;
  assign w_unused_errclr = ^ERR_CLR;
  assign ERR             = '0;
`endif

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) r_state <= ST_IDLE;
    else         r_state <= w_nxt;
  end

  always_comb begin
    w_nxt      = r_state;
    w_grant_en = 1'b0;
    w_to       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|r_pend) begin
          w_nxt      = ST_ASSERT;
          w_grant_en = 1'b1;
        end
      end
      ST_ASSERT: begin
        if (w_ack) begin
          w_nxt = ST_HOLD;
        end else if (w_to_hit) begin
          w_nxt = ST_COMPLETE;
          w_to  = 1'b1;
        end
      end
      ST_HOLD: begin
        if (r_cnt == HOLD_LAST) w_nxt = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!w_ack) begin
          w_nxt = ST_COMPLETE;
        end else if (w_to_hit) begin
          w_nxt = ST_COMPLETE;
          w_to  = 1'b1;
        end
      end
      ST_COMPLETE: w_nxt = ST_IDLE;
      default:     w_nxt = ST_IDLE;
    endcase
  end

  // Outputs are computed from the next state so REQ/DONE come straight out of flops.
  always_comb begin
    w_ch_nxt   = w_grant_en ? w_gnt_idx : r_ch;
    w_pend_clr = w_grant_en ? w_gnt : '0;
    w_req_nxt  = '0;
    w_done_nxt = '0;
    if (w_nxt == ST_ASSERT || w_nxt == ST_HOLD) w_req_nxt = NUM_CH'(1) << w_ch_nxt;
    if (w_nxt == ST_COMPLETE && !w_to)          w_done_nxt = w_ch_oh;
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_ch   <= IDX_W'(NUM_CH - 1);
      r_pend <= '0;
      r_req  <= '0;
      r_done <= '0;
    end else begin
      r_ch   <= w_ch_nxt;
      r_pend <= (r_pend & ~w_pend_clr) | PEND_SET;
      r_req  <= w_req_nxt;
      r_done <= w_done_nxt;
    end
  end

  // One counter serves HOLD length and the handshake timeout; restarts on every state change.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_cnt <= '0;
    end else if (w_nxt != r_state || r_state == ST_IDLE || r_state == ST_COMPLETE) begin
      r_cnt <= '0;
    end else if (r_cnt != CNT_SAT) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign RESET_REQ = r_req;
  assign PENDING   = r_pend;
  assign DONE      = r_done;
  assign BUSY      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_aha_periph_reset_seq.sv
// Directed bench for aha_periph_reset_seq: handshake timing, round-robin order,
// re-queue, async reset, and timeout behaviour for whichever build is compiled.
module tb_aha_periph_reset_seq;

  localparam int NCH = 11;

  logic           CLK = 1'b0;
  logic           RESETn;
  logic [NCH-1:0] PEND_SET, RESET_REQ, RESET_ACK, PENDING, DONE, ERR, ERR_CLR;
  logic           BUSY;
  logic           auto_ack;
  logic [NCH-1:0] man_ack;
  logic [NCH-1:0] d1 = '0, d2 = '0;
  int             total = 0, bad = 0;

  aha_periph_reset_seq #(
    .NUM_CH(NCH), .HOLD_CYCLES(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .CLK(CLK), .RESETn(RESETn), .PEND_SET(PEND_SET), .RESET_REQ(RESET_REQ),
    .RESET_ACK(RESET_ACK), .PENDING(PENDING), .DONE(DONE), .ERR(ERR),
    .ERR_CLR(ERR_CLR), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // Peripheral model: ACK mirrors REQ two cycles late.
  always @(posedge CLK) begin
    d1 <= RESET_REQ;
    d2 <= d1;
  end
  assign RESET_ACK = auto_ack ? d2 : man_ack;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset;
    RESETn = 1'b0;
    tick;
    tick;
    RESETn = 1'b1;
    tick;
    tick;
    tick;
  endtask

  initial begin
    int             n_exp;
    int             n_done;
    logic [NCH-1:0] oh;

    RESETn   = 1'b0;
    PEND_SET = '0;
    ERR_CLR  = '0;
    man_ack  = '0;
    auto_ack = 1'b1;
    tick;
    tick;
    chk("rst_req", 32'(RESET_REQ), 32'h0);
    chk("rst_pend", 32'(PENDING), 32'h0);
    chk("rst_done", 32'(DONE), 32'h0);
    chk("rst_err", 32'(ERR), 32'h0);
    chk("rst_busy", 32'(BUSY), 32'h0);
    RESETn = 1'b1;
    tick;
    tick;
    tick;

    // single channel 3 handshake, pulse at cycle t
    PEND_SET = 11'h008;
    tick;
    PEND_SET = '0;
    chk("t1_pend", 32'(PENDING), 32'h008);
    chk("t1_req_early", 32'(RESET_REQ), 32'h0);
    chk("t1_busy_early", 32'(BUSY), 32'h0);
    tick;
    for (int c = 2; c <= 8; c++) begin
      chk("t1_req_hi", 32'(RESET_REQ), 32'h008);
      chk("t1_busy", 32'(BUSY), 32'h1);
      tick;
    end
    for (int c = 9; c <= 11; c++) begin
      chk("t1_req_lo", 32'(RESET_REQ), 32'h0);
      chk("t1_done_early", 32'(DONE), 32'h0);
      tick;
    end
    chk("t1_done", 32'(DONE), 32'h008);
    chk("t1_busy_cmpl", 32'(BUSY), 32'h1);
    tick;
    chk("t1_busy_end", 32'(BUSY), 32'h0);
    chk("t1_done_end", 32'(DONE), 32'h0);

    // all channels at once: serviced 0..10 in order
    do_reset;
    PEND_SET = 11'h7FF;
    tick;
    PEND_SET = '0;
    n_exp = 0;
    for (int c = 0; c < 600 && n_exp < NCH; c++) begin
      oh = NCH'(1) << n_exp;
      if (RESET_REQ != '0) chk("t2_req_order", 32'(RESET_REQ), 32'(oh));
      if (DONE != '0) begin
        chk("t2_done_order", 32'(DONE), 32'(oh));
        n_exp++;
      end
      tick;
    end
    chk("t2_done_count", 32'(n_exp), 32'd11);
    chk("t2_idle", 32'(BUSY), 32'h0);

    // re-queue of channel 4 while it is in HOLD
    do_reset;
    PEND_SET = 11'h010;
    tick;
    PEND_SET = '0;
    repeat (5) tick;
    chk("t3_req_hold", 32'(RESET_REQ), 32'h010);
    PEND_SET = 11'h010;
    tick;
    PEND_SET = '0;
    chk("t3_requeued", 32'(PENDING), 32'h010);
    n_done = 0;
    for (int c = 0; c < 80; c++) begin
      if (DONE == 11'h010) n_done++;
      tick;
    end
    chk("t3_done_twice", 32'(n_done), 32'd2);

    // async reset in HOLD of channel 2 with channel 7 queued
    do_reset;
    PEND_SET = 11'h084;
    tick;
    PEND_SET = '0;
    tick;
    chk("t4_req2", 32'(RESET_REQ), 32'h004);
    chk("t4_pend7", 32'(PENDING), 32'h080);
    repeat (4) tick;
    #2 RESETn = 1'b0;
    #1;
    chk("t4_req_drop", 32'(RESET_REQ), 32'h0);
    chk("t4_pend_drop", 32'(PENDING), 32'h0);
    chk("t4_busy_drop", 32'(BUSY), 32'h0);
    tick;
    RESETn = 1'b1;
    n_done = 0;
    for (int c = 0; c < 30; c++) begin
      if (RESET_REQ != '0 || BUSY) n_done++;
      tick;
    end
    chk("t4_no_req_after", 32'(n_done), 32'd0);

    // channel 5 with ACK never rising
    do_reset;
    auto_ack = 1'b0;
    man_ack  = '0;
    PEND_SET = 11'h020;
    tick;
    PEND_SET = '0;
    tick;
`ifdef AHA_RST_SEQ_TIMEOUT_EN
    for (int c = 2; c <= 17; c++) begin
      chk("t5_req_hi", 32'(RESET_REQ), 32'h020);
      tick;
    end
    chk("t5_req_timeout", 32'(RESET_REQ), 32'h0);
    chk("t5_err_set", 32'(ERR), 32'h020);
    chk("t5_no_done", 32'(DONE), 32'h0);
    chk("t5_busy_cmpl", 32'(BUSY), 32'h1);
    tick;
    chk("t5_busy_end", 32'(BUSY), 32'h0);
    chk("t5_no_done2", 32'(DONE), 32'h0);
    chk("t5_err_sticky", 32'(ERR), 32'h020);
    ERR_CLR = 11'h020;
    tick;
    ERR_CLR = '0;
    chk("t5_err_clr", 32'(ERR), 32'h0);
    // clear in the same cycle as the timeout: set wins
    PEND_SET = 11'h020;
    tick;
    PEND_SET = '0;
    tick;
    repeat (15) tick;
    chk("t5_last_assert", 32'(RESET_REQ), 32'h020);
    ERR_CLR = 11'h020;
    tick;
    ERR_CLR = '0;
    chk("t5_set_wins", 32'(ERR), 32'h020);
`else
    for (int c = 0; c < 10000; c++) begin
      if (c % 1000 == 0) begin
        chk("t6_req_held", 32'(RESET_REQ), 32'h020);
        chk("t6_err_zero", 32'(ERR), 32'h0);
      end
      tick;
    end
    chk("t6_req_final", 32'(RESET_REQ), 32'h020);
    chk("t6_busy", 32'(BUSY), 32'h1);
    chk("t6_no_done", 32'(DONE), 32'h0);
    ERR_CLR = 11'h020;
    tick;
    ERR_CLR = '0;
    chk("t6_err_still_zero", 32'(ERR), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
